viterbi_puncture: RTL



---
 rtl/viterbi_pkg.sv | 35 +++
 rtl/viterbi_puncture_pattern.sv | 52 +++++
 rtl/viterbi_puncture.sv | 83 ++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared rate codes, pattern periods and keep masks for the rate-1/2 K=9 puncturer/depuncturer pair.
`default_nettype none

package viterbi_pkg;

   typedef enum logic [1:0] {
      RATE_1_2  = 2'd0,
      RATE_2_3  = 2'd1,
      RATE_3_4  = 2'd2,
      RATE_RSVD = 2'd3
   } rate_e;

   localparam logic [1:0] PERIOD_1_2 = 2'd1;
   localparam logic [1:0] PERIOD_2_3 = 2'd2;
   localparam logic [1:0] PERIOD_3_4 = 2'd3;

   // Keep masks are {A,B}; every entry keeps at least one bit.
   localparam logic [1:0] KEEP_1_2_P0 = 2'b11;
   localparam logic [1:0] KEEP_2_3_P0 = 2'b11;
   localparam logic [1:0] KEEP_2_3_P1 = 2'b10;
   localparam logic [1:0] KEEP_3_4_P0 = 2'b11;
   localparam logic [1:0] KEEP_3_4_P1 = 2'b10;
   localparam logic [1:0] KEEP_3_4_P2 = 2'b01;

   function automatic rate_e normalize_rate(input logic [1:0] code);
      case (code)
         2'd1:    return RATE_2_3;
         2'd2:    return RATE_3_4;
         default: return RATE_1_2;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/viterbi_puncture_pattern.sv
// Combinational puncture-pattern lookup: (rate, phase) -> keep mask {A,B} and last-phase flag.
`default_nettype none

module viterbi_puncture_pattern
   import viterbi_pkg::*;
(
   input  logic [1:0] rate,
   input  logic [1:0] phase,
   output logic [1:0] keep,
   output logic       last
);

   // Out-of-range phases fall onto the final table entry so the counter always wraps.
   always_comb begin
      keep = KEEP_1_2_P0;
      last = 1'b1;
      case (rate)
         RATE_2_3: begin
            if (phase == 2'd0) begin
               keep = KEEP_2_3_P0;
               last = (PERIOD_2_3 == 2'd1);
            end else begin
               keep = KEEP_2_3_P1;
               last = 1'b1;
            end
         end
         RATE_3_4: begin
            case (phase)
               2'd0: begin
                  keep = KEEP_3_4_P0;
                  last = (PERIOD_3_4 == 2'd1);
               end
               2'd1: begin
                  keep = KEEP_3_4_P1;
                  last = (PERIOD_3_4 == 2'd2);
               end
               default: begin
                  keep = KEEP_3_4_P2;
                  last = 1'b1;
               end
            endcase
         end
         default: begin
            keep = KEEP_1_2_P0;
            last = (PERIOD_1_2 == 2'd1);
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/viterbi_puncture.sv
// Punctures encoder symbol pairs (rate 1/2, 2/3, 3/4) and serialises the kept bits onto a valid/ready stream.
`default_nettype none

module viterbi_puncture
   import viterbi_pkg::*;
(
   input  logic       Clock,
   input  logic       Reset,
   input  logic [1:0] InY,
   input  logic       InValid,
   input  logic       InStart,
   output logic       InReady,
   input  logic [1:0] Rate,
   output logic       OutBit,
   output logic       OutValid,
   input  logic       OutReady
);

   logic [1:0] phase;
   logic [1:0] rate_reg;
   logic [1:0] eff_rate;
   logic [1:0] eff_phase;
   logic [1:0] keep;
   logic       last_phase;
   logic [1:0] remain;
   logic [1:0] remain_after;
   logic       hold_b;
   logic       accept;
   logic       xfer;

   // A new rate only takes effect at a period boundary or a frame start.
   always_comb begin
      eff_rate = rate_reg;
      if (InStart || (phase == 2'd0)) begin
         eff_rate = normalize_rate(Rate);
      end
      eff_phase = InStart ? 2'd0 : phase;
   end

   viterbi_puncture_pattern u_pattern (
      .rate  (eff_rate),
      .phase (eff_phase),
      .keep  (keep),
      .last  (last_phase)
   );

   // remain holds the kept bits not yet transferred, including the one on OutBit.
   assign OutValid     = |remain;
   assign xfer         = OutValid && OutReady;
   assign remain_after = remain[1] ? (remain & 2'b01) : 2'b00;
   assign InReady      = (remain == 2'b00) || ((^remain) && xfer);
   assign accept       = InValid && InReady;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         phase    <= 2'd0;
         rate_reg <= 2'd0;
      end else if (accept) begin
         phase    <= last_phase ? 2'd0 : (eff_phase + 2'd1);
         rate_reg <= eff_rate;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         remain <= 2'b00;
         hold_b <= 1'b0;
         OutBit <= 1'b0;
      end else if (accept) begin
         remain <= keep;
         hold_b <= InY[0];
         OutBit <= keep[1] ? InY[1] : InY[0];
      end else if (xfer) begin
         remain <= remain_after;
         if (remain_after[0]) begin
            OutBit <= hold_b;
         end
      end
   end

endmodule

`default_nettype wire
